// File: rtl/sdram_line_fetcher_if.sv
// Local (HPC II) read port between the line fetcher and the SDRAM controller.
interface sdram_line_fetcher_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              local_init_done;
    logic              local_ready;
    logic              local_read_req;
    logic              local_burstbegin;
    logic [ADDR_W-1:0] local_address;
    logic [6:0]        local_size;
    logic [DATA_W-1:0] local_rdata;
    logic              local_rdata_valid;

    modport master (
        input  local_init_done, local_ready, local_rdata, local_rdata_valid,
        output local_read_req, local_burstbegin, local_address, local_size
    );

    modport slave (
        output local_init_done, local_ready, local_rdata, local_rdata_valid,
        input  local_read_req, local_burstbegin, local_address, local_size
    );
endinterface

// File: rtl/sdram_line_fetcher.sv
// Fetches one line of words from SDRAM in credit-limited bursts and streams
// them out through a first-word-fall-through FIFO.
module sdram_line_fetcher #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int LEN_W      = 12
) (
    input  logic                 phy_clk,
    input  logic                 reset_phy_clk_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     line_beats,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow_err,
    sdram_line_fetcher_if.master lb,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic               pend_q, pend_d;
    logic               ovf_q, ovf_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];

    logic [6:0]         bl;
    logic               credit_ok;
    logic               req;
    logic               accept;
    logic               ret;
    logic               push;
    logic               pop;
    logic               full;

    always_comb begin
        bl = (rem_q < LEN_W'(BURST_LEN)) ? 7'(rem_q) : 7'(BURST_LEN);
        // Worst case: every beat in flight lands before anything is popped.
        credit_ok = (SUM_W'(cnt_q) + SUM_W'(outst_q) + SUM_W'(bl)) <= SUM_W'(FIFO_DEPTH);
        req    = (state_q == S_ISSUE) && (rem_q != '0) && credit_ok;
        accept = req && lb.local_ready;
        ret    = lb.local_rdata_valid && (outst_q != '0);
        full   = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop    = out_valid && out_ready;
        push   = ret && (!full || pop);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        ovf_d    = ovf_q;
        done     = 1'b0;
        outst_d  = outst_q + (accept ? CNT_W'(bl) : '0) - (ret ? CNT_W'(1) : '0);
        pend_d   = req && !lb.local_ready;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (push ? CNT_W'(1) : '0) - (pop ? CNT_W'(1) : '0);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_INIT;
                    addr_d  = base_addr;
                    rem_d   = line_beats;
                    ovf_d   = 1'b0;
                end
            end
            S_WAIT_INIT: begin
                if (lb.local_init_done)
                    state_d = (rem_q == '0) ? S_DRAIN : S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    addr_d = addr_q + ADDR_W'(bl);
                    rem_d  = rem_q - LEN_W'(bl);
                    if (rem_q == LEN_W'(bl))
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (outst_q == '0) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (lb.local_rdata_valid && !push)
            ovf_d = 1'b1;
    end

    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            outst_q  <= '0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            outst_q  <= outst_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge phy_clk) begin
        if (push)
            mem[wr_ptr_q] <= lb.local_rdata;
    end

    // Request and its address/size derive from registers that only move on
    // acceptance, so they stay stable while the controller stalls.
    assign lb.local_read_req   = req;
    assign lb.local_burstbegin = req && !pend_q;
    assign lb.local_address    = addr_q;
    assign lb.local_size       = (state_q == S_ISSUE) ? bl : '0;

    assign busy         = (state_q != S_IDLE);
    assign overflow_err = ovf_q;
    assign out_valid    = (cnt_q != '0);
    assign out_data     = out_valid ? mem[rd_ptr_q] : '0;
endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Bench for sdram_line_fetcher: SDRAM response model plus output scoreboard.
module tb_sdram_line_fetcher;
    localparam int ADDR_W = 24, DATA_W = 32, BURST_LEN = 8, FIFO_DEPTH = 16, LEN_W = 12;
    localparam int LAT = 4;

    logic              phy_clk = 1'b0;
    logic              reset_phy_clk_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  line_beats;
    logic              busy, done, overflow_err;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_ready;

    sdram_line_fetcher_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) lb ();

    sdram_line_fetcher #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .phy_clk(phy_clk), .reset_phy_clk_n(reset_phy_clk_n),
        .start(start), .base_addr(base_addr), .line_beats(line_beats),
        .busy(busy), .done(done), .overflow_err(overflow_err),
        .lb(lb),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 phy_clk = ~phy_clk;

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [23:0] a);
        return {8'hC3, a} ^ {a[7:0], 24'h5A5A5A};
    endfunction

    typedef struct {
        logic [23:0] addr;
        int          due;
    } beat_t;

    beat_t       rsp_q[$];
    logic [31:0] exp_q[$];
    logic [23:0] ra_q[$];
    int          rs_q[$];
    int cyc = 0, in_flight = 0, done_cnt = 0, req_idx = 0, last_due = 0;
    int stall_idx = -1, stall_left = 0, stall_seen = 0;
    bit pend = 0, inject = 0, any_req = 0;
    logic [23:0] hold_a;
    logic [6:0]  hold_s;

    // Controller model and output consumer, acting on the falling edge.
    initial begin
        lb.local_ready       = 1'b1;
        lb.local_rdata_valid = 1'b0;
        lb.local_rdata       = '0;
        lb.local_init_done   = 1'b1;
        forever begin
            @(negedge phy_clk);
            cyc++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                    in_flight--;
                end
            end
            if (lb.local_read_req) begin
                any_req = 1;
                chk("burstbegin", 32'(lb.local_burstbegin), 32'(!pend));
                if (pend) begin
                    chk("hold_addr", 32'(lb.local_address), 32'(hold_a));
                    chk("hold_size", 32'(lb.local_size), 32'(hold_s));
                end
                hold_a = lb.local_address;
                hold_s = lb.local_size;
                if (req_idx == stall_idx && stall_left > 0) begin
                    lb.local_ready = 1'b0;
                    stall_left--;
                    stall_seen++;
                    pend = 1;
                end else begin
                    lb.local_ready = 1'b1;
                    pend = 0;
                    ra_q.push_back(lb.local_address);
                    rs_q.push_back(int'(lb.local_size));
                    for (int i = 0; i < int'(lb.local_size); i++) begin
                        int d;
                        logic [23:0] a;
                        d = (cyc + LAT > last_due + 1) ? cyc + LAT : last_due + 1;
                        a = lb.local_address + 24'(i);
                        rsp_q.push_back('{a, d});
                        last_due = d;
                    end
                    in_flight += int'(lb.local_size);
                    chk("credit", 32'(in_flight <= FIFO_DEPTH), 32'd1);
                    req_idx++;
                end
            end else begin
                lb.local_ready = 1'b1;
                pend = 0;
                if (lb.local_burstbegin) chk("burstbegin_no_req", 32'(lb.local_burstbegin), 32'd0);
            end
            if (inject) begin
                lb.local_rdata_valid = 1'b1;
                lb.local_rdata       = 32'hDEADBEEF;
                inject = 0;
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                beat_t b;
                b = rsp_q.pop_front();
                lb.local_rdata_valid = 1'b1;
                lb.local_rdata       = mem_word(b.addr);
            end else begin
                lb.local_rdata_valid = 1'b0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic do_start(input logic [23:0] base, input int beats);
        start      = 1'b1;
        base_addr  = base;
        line_beats = LEN_W'(beats);
        for (int i = 0; i < beats; i++) begin
            logic [23:0] a;
            a = base + 24'(i);
            exp_q.push_back(mem_word(a));
        end
        ra_q.delete();
        rs_q.delete();
        req_idx = 0;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finish_fetch(input int mode);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        chk("finish_in_time", 32'(n < 3000), 32'd1);
    endtask

    task automatic run_fetch(input logic [23:0] base, input int beats, input int mode,
                             input int nreq, input int last);
        int d0 = done_cnt;
        do_start(base, beats);
        finish_fetch(mode);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("nreq", 32'(ra_q.size()), 32'(nreq));
        for (int k = 0; k < ra_q.size(); k++) begin
            logic [23:0] ea;
            ea = base + 24'(8 * k);
            chk("req_addr", 32'(ra_q[k]), 32'(ea));
        end
        if (rs_q.size() > 0) chk("last_size", 32'(rs_q[$]), 32'(last));
        chk("no_overflow", 32'(overflow_err), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    typedef struct {
        logic [23:0] base;
        int          beats;
        int          mode;
        int          nreq;
        int          last;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int d0, sum, n;
        tbl[0] = '{24'h000100, 20, 0, 3, 4};
        tbl[1] = '{24'h000200,  8, 0, 1, 8};
        tbl[2] = '{24'h000300,  1, 1, 1, 1};
        tbl[3] = '{24'hFFFFFC, 10, 0, 2, 2};
        tbl[4] = '{24'h000400, 37, 1, 5, 5};

        reset_phy_clk_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        line_beats = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow_err), 32'd0);
        chk("rst_req", 32'(lb.local_read_req), 32'd0);
        chk("rst_bb", 32'(lb.local_burstbegin), 32'd0);
        chk("rst_addr", 32'(lb.local_address), 32'd0);
        chk("rst_size", 32'(lb.local_size), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        reset_phy_clk_n = 1'b1;
        tick();

        foreach (tbl[i]) run_fetch(tbl[i].base, tbl[i].beats, tbl[i].mode, tbl[i].nreq, tbl[i].last);

        // Consumer stalled: only one FIFO's worth may be requested.
        out_ready = 1'b0;
        d0 = done_cnt;
        do_start(24'h000900, 40);
        repeat (60) tick();
        sum = 0;
        foreach (rs_q[i]) sum += rs_q[i];
        chk("t2_beats_held", 32'(sum), 32'd16);
        chk("t2_req_low", 32'(lb.local_read_req), 32'd0);
        finish_fetch(0);
        sum = 0;
        foreach (rs_q[i]) sum += rs_q[i];
        chk("t2_beats_total", 32'(sum), 32'd40);
        chk("t2_ovf", 32'(overflow_err), 32'd0);
        chk("t2_done", 32'(done_cnt - d0), 32'd1);

        // Controller stall on the second request.
        stall_idx = 1;
        stall_left = 5;
        stall_seen = 0;
        run_fetch(24'h000A00, 24, 0, 3, 8);
        chk("t3_stall_cycles", 32'(stall_seen), 32'd5);
        stall_idx = -1;

        // Calibration pending holds off all requests.
        lb.local_init_done = 1'b0;
        any_req = 0;
        d0 = done_cnt;
        do_start(24'h000B00, 8);
        repeat (100) tick();
        chk("t4_no_req", 32'(any_req), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        lb.local_init_done = 1'b1;
        finish_fetch(0);
        chk("t4_nreq", 32'(ra_q.size()), 32'd1);
        chk("t4_done", 32'(done_cnt - d0), 32'd1);

        d0 = done_cnt;
        do_start(24'h000C00, 0);
        chk("t4z_done_early", 32'(done), 32'd0);
        tick();
        chk("t4z_done", 32'(done), 32'd1);
        tick();
        chk("t4z_idle", 32'(busy), 32'd0);
        chk("t4z_noreq", 32'(ra_q.size()), 32'd0);
        chk("t4z_pulses", 32'(done_cnt - d0), 32'd1);

        // Unexpected read data while idle.
        inject = 1;
        repeat (3) tick();
        chk("t5_ovf_set", 32'(overflow_err), 32'd1);
        chk("t5_fifo_empty", 32'(out_valid), 32'd0);
        do_start(24'h000D00, 5);
        chk("t5_ovf_cleared", 32'(overflow_err), 32'd0);
        finish_fetch(0);
        chk("t5_nreq", 32'(ra_q.size()), 32'd1);

        // Asynchronous reset mid-burst.
        do_start(24'h000E00, 24);
        n = 0;
        while (ra_q.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("t6_reached_burst", 32'(n < 200), 32'd1);
        repeat (2) tick();
        @(negedge phy_clk);
        #2;
        reset_phy_clk_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_req", 32'(lb.local_read_req), 32'd0);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_data", out_data, 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        rsp_q.delete();
        exp_q.delete();
        in_flight = 0;
        pend = 0;
        last_due = 0;
        repeat (3) tick();
        reset_phy_clk_n = 1'b1;
        tick();
        chk("t6_idle_after_rst", 32'(busy), 32'd0);
        run_fetch(24'h000F00, 12, 1, 2, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
